// File: rtl/stream_mux_rr.sv
// N-channel stream mux with fixed-select or round-robin grant and a registered output slot.
// Define STREAM_MUX_STALL_CNT_EN to add a saturating 16-bit output stall counter port.
module stream_mux_rr #(
  parameter int WIDTH  = 4,
  parameter int NUM_CH = 4,
  localparam int SEL_W = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]       in_valid,
  output logic [NUM_CH-1:0]       in_ready,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
`ifdef STREAM_MUX_STALL_CNT_EN
  output logic [SEL_W-1:0]        out_ch,
  output logic [15:0]             stall_cnt
`else
  output logic [SEL_W-1:0]        out_ch
`endif
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t             state_reg, state_next;
  logic [WIDTH-1:0]   data_reg;
  logic [SEL_W-1:0]   ch_reg;
  logic [SEL_W-1:0]   rr_ptr_reg;

  logic [WIDTH-1:0]   ch_data [NUM_CH];
  logic               sel_ok;
  logic               fix_valid;
  logic               rr_valid;
  logic [SEL_W-1:0]   rr_grant;
  logic               grant_valid;
  logic [SEL_W-1:0]   grant;
  logic               load_en;
  logic               xfer;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign ch_data[gi]  = in_data[gi*WIDTH +: WIDTH];
      assign in_ready[gi] = xfer && (grant == SEL_W'(gi));
    end

    // When NUM_CH is a power of two every sel encoding is a real channel.
    if ((1 << SEL_W) == NUM_CH) begin : g_sel_full
      assign sel_ok = 1'b1;
    end else begin : g_sel_part
      assign sel_ok = (int'(sel) < NUM_CH);
    end
  endgenerate

  assign fix_valid = sel_ok && in_valid[sel];

  // Channels above rr_ptr take precedence over those at or below it; lowest index wins in each group.
  always_comb begin
    rr_valid = 1'b0;
    rr_grant = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (in_valid[i] && (SEL_W'(i) <= rr_ptr_reg)) begin
        rr_valid = 1'b1;
        rr_grant = SEL_W'(i);
      end
    end
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (in_valid[i] && (SEL_W'(i) > rr_ptr_reg)) begin
        rr_valid = 1'b1;
        rr_grant = SEL_W'(i);
      end
    end
  end

  assign grant_valid = mode ? rr_valid : fix_valid;
  assign grant       = mode ? rr_grant : sel;

  always_comb begin
    state_next = state_reg;
    load_en    = (state_reg == EMPTY) || out_ready;
    xfer       = load_en && grant_valid;
    if (load_en) begin
      state_next = grant_valid ? FULL : EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= EMPTY;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_reg   <= '0;
      ch_reg     <= '0;
      rr_ptr_reg <= SEL_W'(NUM_CH - 1);
    end else if (xfer) begin
      data_reg   <= ch_data[grant];
      ch_reg     <= grant;
      rr_ptr_reg <= grant;
    end
  end

  assign out_valid = (state_reg == FULL);
  assign out_data  = data_reg;
  assign out_ch    = ch_reg;

`ifdef STREAM_MUX_STALL_CNT_EN
  logic [15:0] stall_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_reg <= '0;
    end else if (out_valid && !out_ready && (stall_cnt_reg != 16'hFFFF)) begin
      stall_cnt_reg <= stall_cnt_reg + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr: fixed select, round-robin, backpressure, no-grant drain, async reset.
`timescale 1ns/1ps
module tb_stream_mux_rr;
  localparam int WIDTH  = 4;
  localparam int NUM_CH = 4;

  logic                    clk;
  logic                    rst_n;
  logic [NUM_CH*WIDTH-1:0] in_data;
  logic [NUM_CH-1:0]       in_valid;
  logic [NUM_CH-1:0]       in_ready;
  logic                    mode;
  logic [1:0]              sel;
  logic [WIDTH-1:0]        out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [1:0]              out_ch;
`ifdef STREAM_MUX_STALL_CNT_EN
  logic [15:0]             stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  stream_mux_rr #(.WIDTH(WIDTH), .NUM_CH(NUM_CH)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .mode(mode),
    .sel(sel),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_ch(out_ch)
`ifdef STREAM_MUX_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench timed out");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 4'b0000; out_ready = 1'b1; mode = 1'b0; sel = 2'd0;
    in_data = {4'd4, 4'd3, 4'd2, 4'd1};
    #2;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 4'd0 || out_ch !== 2'd0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b d=%0d ch=%0d want v=0 d=0 ch=0", out_valid, out_data, out_ch);
    end
    checks++;
    if (in_ready !== 4'b0000) begin
      errors++;
      $display("FAIL reset_in_ready got %b want 0000", in_ready);
    end
`ifdef STREAM_MUX_STALL_CNT_EN
    checks++;
    if (stall_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_stall_cnt got %0d want 0", stall_cnt);
    end
`endif
    rst_n = 1'b1;
  endtask

  task automatic test_fixed();
    logic [3:0] exp_data [4] = '{4'd1, 4'd2, 4'd3, 4'd4};
    logic [3:0] exp_rdy  [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    logic [1:0] exp_ch   [4] = '{2'd0, 2'd1, 2'd2, 2'd3};
    mode = 1'b0; in_valid = 4'b1111; out_ready = 1'b1;
    for (int s = 0; s < 4; s++) begin
      sel = exp_ch[s];
      #1;
      checks++;
      if (in_ready !== exp_rdy[s]) begin
        errors++;
        $display("FAIL fixed_in_ready sel=%0d got %b want %b", s, in_ready, exp_rdy[s]);
      end
      tick();
      $display("fixed sel=%0d out_ch=%0d out_data=%0d out_valid=%b", s, out_ch, out_data, out_valid);
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp_data[s] || out_ch !== exp_ch[s]) begin
        errors++;
        $display("FAIL fixed_out sel=%0d got v=%b d=%0d ch=%0d want v=1 d=%0d ch=%0d",
                 s, out_valid, out_data, out_ch, exp_data[s], exp_ch[s]);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_ch   [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [3:0] exp_data [5] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd1};
    do_reset();
    mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 4'b0001) begin
      errors++;
      $display("FAIL rr_first_in_ready got %b want 0001", in_ready);
    end
    for (int k = 0; k < 5; k++) begin
      tick();
      $display("rr k=%0d out_ch=%0d out_data=%0d out_valid=%b", k, out_ch, out_data, out_valid);
      checks++;
      if (out_valid !== 1'b1 || out_ch !== exp_ch[k] || out_data !== exp_data[k]) begin
        errors++;
        $display("FAIL rr_seq k=%0d got v=%b ch=%0d d=%0d want v=1 ch=%0d d=%0d",
                 k, out_valid, out_ch, out_data, exp_ch[k], exp_data[k]);
      end
    end
  endtask

  task automatic test_sparse_rr();
    logic [1:0] exp_ch   [3] = '{2'd1, 2'd3, 2'd1};
    logic [3:0] exp_data [3] = '{4'd2, 4'd4, 4'd2};
    in_valid = 4'b1010;
    #1;
    checks++;
    if (in_ready !== 4'b0010) begin
      errors++;
      $display("FAIL sparse_in_ready got %b want 0010", in_ready);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      $display("sparse k=%0d out_ch=%0d out_data=%0d", k, out_ch, out_data);
      checks++;
      if (out_valid !== 1'b1 || out_ch !== exp_ch[k] || out_data !== exp_data[k]) begin
        errors++;
        $display("FAIL sparse_seq k=%0d got v=%b ch=%0d d=%0d want v=1 ch=%0d d=%0d",
                 k, out_valid, out_ch, out_data, exp_ch[k], exp_data[k]);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    mode = 1'b0; sel = 2'd2; in_valid = 4'b1111; out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 4'd3) begin
      errors++;
      $display("FAIL bp_load got v=%b d=%0d want v=1 d=3", out_valid, out_data);
    end
    out_ready = 1'b0;
    #1;
    checks++;
    if (in_ready !== 4'b0000) begin
      errors++;
      $display("FAIL bp_in_ready got %b want 0000", in_ready);
    end
    for (int k = 0; k < 5; k++) begin
      tick();
      $display("stall k=%0d out_data=%0d out_ch=%0d in_ready=%b", k, out_data, out_ch, in_ready);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 4'd3 || out_ch !== 2'd2 || in_ready !== 4'b0000) begin
        errors++;
        $display("FAIL bp_hold k=%0d got v=%b d=%0d ch=%0d rdy=%b want v=1 d=3 ch=2 rdy=0000",
                 k, out_valid, out_data, out_ch, in_ready);
      end
    end
`ifdef STREAM_MUX_STALL_CNT_EN
    checks++;
    if (stall_cnt !== 16'd5) begin
      errors++;
      $display("FAIL bp_stall_cnt got %0d want 5", stall_cnt);
    end
`endif
    sel = 2'd3; out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 4'b1000) begin
      errors++;
      $display("FAIL bp_release_in_ready got %b want 1000", in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 4'd4 || out_ch !== 2'd3) begin
      errors++;
      $display("FAIL bp_release got v=%b d=%0d ch=%0d want v=1 d=4 ch=3", out_valid, out_data, out_ch);
    end
`ifdef STREAM_MUX_STALL_CNT_EN
    checks++;
    if (stall_cnt !== 16'd5) begin
      errors++;
      $display("FAIL bp_stall_cnt_hold got %0d want 5", stall_cnt);
    end
`endif
  endtask

  task automatic test_no_grant();
    mode = 1'b0; sel = 2'd2; in_valid = 4'b1011; out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 4'b0000) begin
      errors++;
      $display("FAIL nogrant_in_ready got %b want 0000", in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 4'd4 || out_ch !== 2'd3) begin
      errors++;
      $display("FAIL nogrant_drain got v=%b d=%0d ch=%0d want v=0 d=4 ch=3", out_valid, out_data, out_ch);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL nogrant_empty got v=%b want v=0", out_valid);
    end
  endtask

  task automatic test_async_reset();
    mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
    tick();
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_ch !== 2'd1 || out_data !== 4'd2) begin
      errors++;
      $display("FAIL arst_pre got v=%b ch=%0d d=%0d want v=1 ch=1 d=2", out_valid, out_ch, out_data);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 4'd0 || out_ch !== 2'd0) begin
      errors++;
      $display("FAIL arst_clear got v=%b d=%0d ch=%0d want v=0 d=0 ch=0", out_valid, out_data, out_ch);
    end
    tick();
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 4'b0001) begin
      errors++;
      $display("FAIL arst_rr_in_ready got %b want 0001", in_ready);
    end
    tick();
    $display("post-reset out_ch=%0d out_data=%0d", out_ch, out_data);
    checks++;
    if (out_valid !== 1'b1 || out_ch !== 2'd0 || out_data !== 4'd1) begin
      errors++;
      $display("FAIL arst_first_grant got v=%b ch=%0d d=%0d want v=1 ch=0 d=1", out_valid, out_ch, out_data);
    end
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_round_robin();
    test_sparse_rr();
    test_backpressure();
    test_no_grant();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stream_mux_rr.md
Name: stream_mux_rr

Overview:
- Parametrised N-channel, W-bit stream multiplexer; successor to the combinational 4:1 mux.
- Each input has a valid/ready handshake. A grant stage picks one channel per cycle, either by fixed `sel` or by round-robin.
- The selected word is captured in a single output register with a valid/ready handshake.
- Sits between multiple producers and one downstream consumer.

Parameters:
- WIDTH, 4, data width per channel.
- NUM_CH, 4, number of input channels (>=2).
- SEL_W is a localparam: $clog2(NUM_CH). Not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  NUM_CH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  NUM_CH  per-channel valid.
- in_ready  output  NUM_CH  per-channel ready; combinational.
- mode  input  1  0 = fixed select via sel; 1 = round-robin.
- sel  input  SEL_W  channel index used when mode=0.
- out_data  output  WIDTH  registered data.
- out_valid  output  1  registered valid.
- out_ready  input  1  downstream ready.
- out_ch  output  SEL_W  index of the channel that produced out_data; registered.

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset values: out_valid=0, out_data=0, out_ch=0, rr_ptr=NUM_CH-1. With this rr_ptr, the first round-robin search starts at channel 0.
- Output stage states:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
- load_en = !out_valid | out_ready. A new word can be captured while the current one drains, giving full throughput with no bubble.
- Grant logic (combinational):
  - mode=0: grant = sel if sel<NUM_CH and in_valid[sel]; otherwise no grant. sel>=NUM_CH never grants.
  - mode=1: grant = first i with in_valid[i] set, searching (rr_ptr+1) mod NUM_CH upward with wrap-around; no grant if all in_valid are 0.
- in_ready[i] = load_en & grant_valid & (grant==i). At most one bit is set per cycle. in_ready never depends on the in_valid of other channels except through grant selection.
- Transfer in: on a clock edge with in_valid[g] & in_ready[g]:
  - out_data <= channel g data; out_ch <= g; out_valid <= 1; rr_ptr <= g.
  - rr_ptr updates in both modes, so a switch from mode 0 to mode 1 resumes after the last granted channel.
- Drain without refill: out_valid & out_ready with no grant → out_valid <= 0 (FULL→EMPTY). out_data and out_ch hold their last values.
- Stall: out_valid & !out_ready → out_data and out_ch stable; all in_ready=0; rr_ptr unchanged.
- Latency: one cycle from input handshake to out_valid.
- mode and sel changes affect only the next grant. Registered contents are never altered.
- Reset asserted mid-operation: all state is cleared immediately, regardless of clk. Any word held in the output register is dropped.
- No combinational path from out_ready to out_data or out_valid. The path from out_ready to in_ready is permitted.

Optional Feature:
- Macro: STREAM_MUX_STALL_CNT_EN.
- Defined: adds output port stall_cnt (16 bits).
  - Increments each cycle with out_valid & !out_ready.
  - Saturates at 16'hFFFF.
  - Reset to 0 by rst_n.
  - Never clears otherwise.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Use NUM_CH=4, WIDTH=4 and data ch0..ch3 = 1,2,3,4 throughout.
- Fixed mode: mode=0, all valid, out_ready=1; sel=0,1,2,3 each for 10 ns → out_data 1,2,3,4 one cycle after each sel change; out_ch matches sel; in_ready one-hot on sel.
- Round-robin: mode=1, all valid, out_ready=1 after reset → out_ch sequence 0,1,2,3,0 on consecutive cycles; out_valid held at 1 with no bubbles.
- Sparse round-robin: in_valid=4'b1010, mode=1 → out_ch alternates 1,3,1; out_data alternates 2,4.
- Backpressure: FULL with out_data=3, hold out_ready=0 for 5 cycles → out_data stays 3; in_ready=0; with STREAM_MUX_STALL_CNT_EN, stall_cnt=5. Release → next word the following cycle.
- Edge cases:
  - mode=0, sel=2, in_valid[2]=0 → out_valid falls to 0 after drain; in_ready=0.
  - Assert rst_n=0 asynchronously mid-transfer → out_valid=0, out_data=0 immediately.
  - After release, mode=1 grants channel 0 first.
